// File: rtl/instr_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | instr_loader_pkg: shared types and constants for the loader  |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
package instr_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } loader_state_t;

  localparam int         LEN_BYTES  = 4;
  localparam int         WORD_BYTES = 4;
  localparam logic [7:0] CSUM_INIT  = 8'h00;

endpackage
`default_nettype wire

// File: rtl/instr_loader_word_packer.sv
`default_nettype none
// +--------------------------------------------------------------+
// | word_packer: little-endian byte-to-word packer               |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module word_packer
  import instr_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_W     = WORD_BYTES * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [DATA_WIDTH-1:0] byte_in,
  output logic                  word_valid,
  output logic [WORD_W-1:0]     word
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  logic [1:0]        idx;
  logic [WORD_W-1:0] pack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= 2'd0;
      pack <= '0;
    end else if (clear) begin
      idx  <= 2'd0;
      pack <= '0;
    end else if (byte_valid) begin
      idx <= idx + 2'd1;
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (idx == 2'(i)) pack[i*DATA_WIDTH +: DATA_WIDTH] <= byte_in;
      end
    end
  end

  // The completed word includes the byte arriving this cycle so the
  // top level can register it on the same edge that accepts it.
  always_comb begin
    word = pack;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (idx == 2'(i)) word[i*DATA_WIDTH +: DATA_WIDTH] = byte_in;
    end
  end

  assign word_valid = byte_valid && (idx == LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// +--------------------------------------------------------------+
// | instr_loader: length/checksum-framed byte stream to IMEM     |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 20,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      in_ready,
  output logic                      wr_en,
  output logic [ADDRESS_WIDTH-1:0]  wr_addr,
  output logic [4*DATA_WIDTH-1:0]   wr_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int         LW        = LEN_BYTES * DATA_WIDTH;
  localparam int         WW        = WORD_BYTES * DATA_WIDTH;
  localparam int         CW        = ADDRESS_WIDTH - 1;
  localparam logic [1:0] LEN_LAST  = 2'(LEN_BYTES - 1);
  localparam logic [LW:0] MAX_WORDS = (LW+1)'(1) << (ADDRESS_WIDTH - 2);

  loader_state_t         state;
  logic [LW-1:0]         len;
  logic [LW-1:0]         len_next;
  logic [1:0]            len_idx;
  logic [CW-1:0]         word_cnt;
  logic [DATA_WIDTH-1:0] csum;
  logic                  start_ok;
  logic                  word_valid;
  logic [WW-1:0]         word;

  assign busy     = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign in_ready = busy;
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign len_next = {in_data, len[LW-1:DATA_WIDTH]};

  word_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORD_W     (WW)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .byte_valid (in_valid && (state == S_DATA)),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      len      <= '0;
      len_idx  <= 2'd0;
      word_cnt <= '0;
      csum     <= DATA_WIDTH'(CSUM_INIT);
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (word_valid) begin
        wr_en   <= 1'b1;
        wr_addr <= {word_cnt[CW-2:0], 2'b00};
        wr_data <= word;
      end

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_LEN;
            done     <= 1'b0;
            err      <= 1'b0;
            len      <= '0;
            len_idx  <= 2'd0;
            word_cnt <= '0;
            csum     <= DATA_WIDTH'(CSUM_INIT);
          end
        end
        S_LEN: begin
          if (in_valid) begin
            len     <= len_next;
            len_idx <= len_idx + 2'd1;
            csum    <= csum ^ in_data;
            if (len_idx == LEN_LAST) begin
              if ({1'b0, len_next} > MAX_WORDS) begin
                state <= S_ERR;
                err   <= 1'b1;
              end else if (len_next == '0) begin
                state <= S_CSUM;
              end else begin
                state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (in_valid) csum <= csum ^ in_data;
          // N is bounded by MAX_WORDS here, so its low CW bits are exact.
          if (word_valid) begin
            word_cnt <= word_cnt + CW'(1);
            if ((word_cnt + CW'(1)) == len[CW-1:0]) state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (in_valid) begin
            if (in_data == csum) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// Bench for instr_loader: table of framed streams plus hand-written
// sequences for the oversize/boundary (ADDRESS_WIDTH=4) and mid-load reset cases.
module tb_instr_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        start4;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        in_ready, wr_en, busy, done, err;
  logic [19:0] wr_addr;
  logic [31:0] wr_data;

  logic        in_ready4, wr_en4, busy4, done4, err4;
  logic [3:0]  wr_addr4;
  logic [31:0] wr_data4;

  int checks = 0;
  int errors = 0;

  instr_loader #(.ADDRESS_WIDTH(20), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  instr_loader #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready4), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
    .busy(busy4), .done(done4), .err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] addr;
    logic [31:0] data;
    logic        busy_at;
    logic        done_at;
  } wr_t;

  wr_t         wq[$];
  logic [35:0] w4q[$];

  always @(negedge clk) begin
    if (wr_en)  wq.push_back('{wr_addr, wr_data, busy, done});
    if (wr_en4) w4q.push_back({wr_addr4, wr_data4});
  end

  typedef struct {
    int                nb;
    logic [0:19][7:0]  b;
    bit                gaps;
    bit                mstart;
    int                nw;
    logic [0:2][31:0]  w;
    logic              dn;
    logic              er;
  } vec_t;

  vec_t       tv[6];
  logic [7:0] bq[$];

  function automatic vec_t mk(input int nb, input logic [0:19][7:0] b, input bit g,
                              input bit ms, input int nw, input logic [0:2][31:0] w,
                              input logic dn, input logic er);
    vec_t v;
    v.nb = nb; v.b = b; v.gaps = g; v.mstart = ms; v.nw = nw; v.w = w; v.dn = dn; v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input bit four);
    if (four) start4 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start4 = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the last byte's transfer edge.
  task automatic send_stream(input logic [7:0] q[$], input bit gaps, input bit mid_start);
    foreach (q[i]) begin
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = q[i];
      if (mid_start && i == 6) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_wr_en"},    {31'd0, wr_en},    32'd0);
    chk({tag, "_wr_addr"},  {12'd0, wr_addr},  32'd0);
    chk({tag, "_wr_data"},  wr_data,           32'd0);
    chk({tag, "_busy"},     {31'd0, busy},     32'd0);
    chk({tag, "_done"},     {31'd0, done},     32'd0);
    chk({tag, "_err"},      {31'd0, err},      32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; start4 = 1'b0; in_valid = 1'b0; in_data = 8'h00;

    tv[0] = mk(13, {8'h02,8'h00,8'h00,8'h00, 8'h13,8'h00,8'h00,8'h00,
                    8'h93,8'h00,8'h10,8'h00, 8'h92, 56'h0},
               0, 0, 2, {32'h00000013, 32'h00100093, 32'h0}, 1'b1, 1'b0);
    tv[1] = mk(13, {8'h02,8'h00,8'h00,8'h00, 8'h13,8'h00,8'h00,8'h00,
                    8'h93,8'h00,8'h10,8'h00, 8'h6D, 56'h0},
               0, 0, 2, {32'h00000013, 32'h00100093, 32'h0}, 1'b0, 1'b1);
    tv[2] = mk(5, {8'h00,8'h00,8'h00,8'h00, 8'h00, 120'h0},
               0, 0, 0, {32'h0, 32'h0, 32'h0}, 1'b1, 1'b0);
    tv[3] = mk(5, {8'h00,8'h00,8'h00,8'h00, 8'h01, 120'h0},
               0, 0, 0, {32'h0, 32'h0, 32'h0}, 1'b0, 1'b1);
    tv[4] = mk(17, {8'h03,8'h00,8'h00,8'h00, 8'h11,8'h22,8'h33,8'h44,
                    8'h55,8'h66,8'h77,8'h88, 8'h01,8'h02,8'h04,8'h08, 8'h84, 24'h0},
               0, 0, 3, {32'h44332211, 32'h88776655, 32'h08040201}, 1'b1, 1'b0);
    tv[5] = mk(17, {8'h03,8'h00,8'h00,8'h00, 8'h11,8'h22,8'h33,8'h44,
                    8'h55,8'h66,8'h77,8'h88, 8'h01,8'h02,8'h04,8'h08, 8'h84, 24'h0},
               1, 1, 3, {32'h44332211, 32'h88776655, 32'h08040201}, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    check_idle_outputs("rst");
    chk("rst4_ready", {31'd0, in_ready4}, 32'd0);
    chk("rst4_err",   {31'd0, err4},      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      wq.delete();
      bq.delete();
      for (int i = 0; i < tv[t].nb; i++) bq.push_back(tv[t].b[i]);
      pulse_start(1'b0);
      send_stream(bq, tv[t].gaps, tv[t].mstart);
      chk($sformatf("v%0d_nwrites", t), 32'(wq.size()), 32'(tv[t].nw));
      for (int k = 0; k < tv[t].nw && k < wq.size(); k++) begin
        chk($sformatf("v%0d_addr%0d", t, k), {12'd0, wq[k].addr}, 32'(4 * k));
        chk($sformatf("v%0d_data%0d", t, k), wq[k].data, tv[t].w[k]);
        chk($sformatf("v%0d_wr_before_done%0d", t, k),
            {30'd0, wq[k].busy_at, wq[k].done_at}, 32'd2);
      end
      chk($sformatf("v%0d_done", t),  {31'd0, done},     {31'd0, tv[t].dn});
      chk($sformatf("v%0d_err", t),   {31'd0, err},      {31'd0, tv[t].er});
      chk($sformatf("v%0d_busy", t),  {31'd0, busy},     32'd0);
      chk($sformatf("v%0d_ready", t), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_nwrites_after", t), 32'(wq.size()), 32'(tv[t].nw));
    end

    // Oversize word count on the 16-byte memory: ERR right after the 4th length byte.
    w4q.delete();
    bq = {8'h05, 8'h00, 8'h00, 8'h00};
    pulse_start(1'b1);
    send_stream(bq, 0, 0);
    chk("ovr_err",   {31'd0, err4},      32'd1);
    chk("ovr_done",  {31'd0, done4},     32'd0);
    chk("ovr_ready", {31'd0, in_ready4}, 32'd0);
    chk("ovr_busy",  {31'd0, busy4},     32'd0);
    bq = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_stream(bq, 0, 0);
    chk("ovr_nwrites", 32'(w4q.size()), 32'd0);

    // N equal to the memory size fills addresses 0..C without wrapping.
    w4q.delete();
    bq = {8'h04, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) bq.push_back(8'(i));
    bq.push_back(8'h04);
    pulse_start(1'b1);
    send_stream(bq, 0, 0);
    chk("full_done",    {31'd0, done4}, 32'd1);
    chk("full_err",     {31'd0, err4},  32'd0);
    chk("full_nwrites", 32'(w4q.size()), 32'd4);
    for (int k = 0; k < 4 && k < w4q.size(); k++) begin
      chk($sformatf("full_wr%0d", k), {28'd0, w4q[k][35:32]}, 32'(4 * k));
      chk($sformatf("full_data%0d", k), w4q[k][31:0],
          {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    end

    // Asynchronous reset after 6 data bytes of an N=2 load.
    wq.delete();
    bq.delete();
    for (int i = 0; i < 10; i++) bq.push_back(tv[0].b[i]);
    pulse_start(1'b0);
    send_stream(bq, 0, 0);
    chk("mid_nwrites_pre", 32'(wq.size()), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_nwrites_post", 32'(wq.size()), 32'd1);
    check_idle_outputs("mid_idle");

    wq.delete();
    bq.delete();
    for (int i = 0; i < tv[0].nb; i++) bq.push_back(tv[0].b[i]);
    pulse_start(1'b0);
    send_stream(bq, 0, 0);
    chk("reload_nwrites", 32'(wq.size()), 32'd2);
    if (wq.size() >= 2) begin
      chk("reload_addr0", {12'd0, wq[0].addr}, 32'd0);
      chk("reload_data0", wq[0].data, 32'h00000013);
      chk("reload_addr1", {12'd0, wq[1].addr}, 32'd4);
      chk("reload_data1", wq[1].data, 32'h00100093);
    end
    chk("reload_done", {31'd0, done}, 32'd1);
    chk("reload_err",  {31'd0, err},  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_loader.md
# instr_loader

Program loader that fills the instruction memory before the core runs. Accepts a byte stream over a valid/ready handshake, checks a length header and an XOR checksum, and packs little-endian bytes into 32-bit instruction words. Issues one write per word into the byte-addressed instruction memory, at byte addresses 0, 4, 8, … . Holds the core off via `busy` until the load has succeeded or failed.

## Interface
- `ADDRESS_WIDTH`, default 20: byte-address width of instruction memory; matches the memory's address width.
- `DATA_WIDTH`, default 8: memory cell width; word is `4*DATA_WIDTH` = 32 bits.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- `in_valid`  in  1  stream byte valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `wr_en`  out  1  one-cycle instruction-memory write strobe.
- `wr_addr`  out  ADDRESS_WIDTH  byte address of word; always a multiple of 4.
- `wr_data`  out  4*DATA_WIDTH  instruction word; byte 0 of the word in bits [7:0].
- `busy`  out  1  load in progress; the core is held while high.
- `done`  out  1  last load completed with a good checksum; held high until the next accepted `start`.
- `err`  out  1  last load failed; held high until the next accepted `start`.

## Operation
- Stream format: 4 length bytes (N, little-endian, word count), then 4·N data bytes, then 1 checksum byte.
- Checksum is the XOR of all length and data bytes.
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR → LEN on `start`; the accepted `start` also clears `done` and `err` and zeroes the byte, word and checksum counters.
- LEN: accept 4 bytes into N.
  - On the 4th byte: if N > 2^(ADDRESS_WIDTH-2), go to ERR.
  - Else if N == 0, go to CSUM.
  - Else go to DATA.
- DATA: accept bytes into a shift/pack register.
  - On every 4th byte, issue a write of the packed word at address 4·k, then increment k.
  - After word N-1 is written, go to CSUM.
- CSUM: accept 1 byte. If it equals the running XOR, go to DONE; else go to ERR.
  - The checksum byte itself is not included in the XOR.
- Writes are never retracted: a failed checksum leaves all data words already written. Software must observe `err`.
- `start` in LEN/DATA/CSUM is ignored.
- `in_valid` while `in_ready` is low is ignored; no byte is consumed.

## Timing
- Reset values: state IDLE, `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `err`=0.
- `in_ready` and `busy` are high exactly in LEN, DATA and CSUM; both are derived combinationally from state.
- Throughput: one byte per cycle; no back-pressure from the memory (it accepts a write every cycle).
- `wr_en`, `wr_addr` and `wr_data` are registered.
  - `wr_en` is high for exactly the one cycle after the 4th byte of a word is transferred.
  - `wr_addr` and `wr_data` hold their values until the next write.
- State enters DONE or ERR on the edge that accepts the checksum byte (or the 4th length byte for an oversize N). `done`/`err` are high in the following cycle.
  - The last `wr_en` pulse coincides with the first cycle of CSUM, so it always precedes `done`.
- Asynchronous reset mid-load: immediate return to IDLE with all outputs at reset values. A partial word is discarded and no write is issued.
- Word-count boundary: N == 2^(ADDRESS_WIDTH-2) is legal. The last address is 2^ADDRESS_WIDTH − 4, and there is no wrap.

## Structure
- Package `instr_loader_pkg` holds:
  - the state enum (`loader_state_t`);
  - `LEN_BYTES`=4;
  - `WORD_BYTES`=4;
  - `CSUM_INIT`=8'h00.
- Sub-module `word_packer`: a 2-bit byte index plus a 32-bit little-endian pack register with a `word_valid` pulse. It is cleared on `start` and reset.
- The top level contains the FSM, the length register, the word counter (ADDRESS_WIDTH-1 bits), the XOR accumulator and the write-port registers.

## Test plan
- N=2, data 13 00 00 00 93 00 10 00, checksum correct, `in_valid` held high → writes 0x00000013 @0 and 0x00100093 @4 on separate single-cycle `wr_en` pulses; then `done`=1, `busy`=0.
- Same stream with the checksum byte flipped → both writes still occur; `err`=1, `done`=0.
- N=0 (00 00 00 00), checksum 00 → no `wr_en`; `done`=1 after 5 byte transfers.
- ADDRESS_WIDTH=4, N=5 → ERR immediately after the 4th length byte; no writes; `in_ready`=0 afterwards.
- `in_valid` toggled randomly during an N=3 load, plus a `start` pulse mid-load → identical writes to the gapless case; the mid-load `start` has no effect.
- `rst_n` pulsed low after 6 data bytes of N=2 → no further `wr_en`; all outputs at reset values. A new `start` plus a full stream then loads correctly from address 0.
